// File: rtl/icap_load_sequencer.sv
// icap_load_sequencer
//   Frames a UART byte stream into a bitstream load and drives the ICAP write
//   port. A load is: 32-bit magic sync word, length word (payload word count
//   in the LEN_W LSBs), N payload words, and a 32-bit additive checksum
//   trailer. Words are big-endian (first byte lands in bits [31:24]).
//   Payload words are buffered in a small FIFO and popped to ICAP whenever
//   icap_busy is low; each pop produces a one-cycle icap_csib=0 strobe on the
//   following cycle.
//   Optional feature macro: ICAP_BITSWAP_EN -- when defined, every byte of
//   the ICAP output word is bit-reversed (ICAPE2 bit ordering). The checksum
//   always covers the unswapped words.
module icap_load_sequencer #(
    parameter int          FIFO_DEPTH  = 16,
    parameter int          LEN_W       = 24,
    parameter logic [31:0] MAGIC       = 32'h5A5AC3C3,
    parameter int          TIMEOUT_CYC = 1000000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_byte_in,
    input  logic        i_byte_valid,
    input  logic        i_abort,
    input  logic        i_icap_busy,
    output logic [31:0] o_icap_data,
    output logic        o_icap_csib,
    output logic        o_icap_rdwrb,
    output logic        o_programming_done,
    output logic        o_load_error,
    output logic [2:0]  o_err_code,
    output logic        o_loader_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_ZERO_LEN = 3'd1;
    localparam logic [2:0] ERR_OVERFLOW = 3'd2;
    localparam logic [2:0] ERR_CHECKSUM = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd4;
    localparam logic [2:0] ERR_ABORT    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_STREAM,
        S_SUM,
        S_DRAIN,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           r_state;
    logic [23:0]      r_shift;
    logic [1:0]       r_bcnt;
    logic [TW-1:0]    r_idle;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_wcnt;
    logic [31:0]      r_sum;
    logic [31:0]      r_trailer;
    logic             r_done;
    logic             r_err;
    logic [2:0]       r_code;

    logic [31:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [CW-1:0]    r_cnt;

    logic [31:0]      r_icap;
    logic             r_csib;

    logic [31:0]      w_word;
    logic             w_last;
    logic             w_framing;
    logic             w_in_load;
    logic             w_writing;
    logic             w_tmo;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_ovf;
    logic             w_push_ok;
    logic             w_flush;

    // Output formatting toward the ICAP primitive
    function automatic logic [31:0] f_icap_format(input logic [31:0] w);
`ifdef ICAP_BITSWAP_EN
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) begin
                r[8*b + i] = w[8*b + 7 - i];
            end
        end
        return r;
`else
        return w;
`endif
    endfunction

    // Current byte completes a big-endian word with the three previous bytes
    assign w_word    = {r_shift, i_byte_in};
    assign w_last    = i_byte_valid && (r_bcnt == 2'd3);

    assign w_framing = (r_state == S_LEN) || (r_state == S_STREAM) || (r_state == S_SUM);
    assign w_in_load = w_framing || (r_state == S_DRAIN);
    assign w_writing = (r_state == S_STREAM) || (r_state == S_SUM) || (r_state == S_DRAIN);

    // The timeout fires on the idle cycle that completes TIMEOUT_CYC silent clocks
    assign w_tmo     = w_framing && !i_byte_valid && (r_idle == TW'(TIMEOUT_CYC - 1));

    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == CW'(FIFO_DEPTH));

    // No pop on a cycle that aborts or fails: the FIFO is discarded instead
    assign w_pop     = w_writing && !w_empty && !i_icap_busy && !i_abort && !w_tmo;
    assign w_push    = (r_state == S_STREAM) && w_last && !i_abort;
    assign w_ovf     = w_push && w_full && !w_pop;
    assign w_push_ok = w_push && !w_ovf;
    assign w_flush   = i_abort || w_tmo || w_ovf;

    // Framing state machine: sync hunt, length, payload, trailer, verdict
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_bcnt  <= '0;
            r_idle  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_code  <= ERR_NONE;
        end else if (i_abort) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_bcnt  <= '0;
            r_done  <= 1'b0;
            r_err   <= w_in_load;
            r_code  <= w_in_load ? ERR_ABORT : ERR_NONE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Clears the one-cycle abort indication
                    r_err  <= 1'b0;
                    r_code <= ERR_NONE;
                    if (i_byte_valid) begin
                        r_shift <= w_word[23:0];
                        if (w_word == MAGIC) begin
                            r_state <= S_LEN;
                            r_bcnt  <= '0;
                            r_idle  <= '0;
                        end
                    end
                end

                S_LEN, S_STREAM, S_SUM: begin
                    if (w_tmo) begin
                        r_state <= S_ERROR;
                        r_err   <= 1'b1;
                        r_code  <= ERR_TIMEOUT;
                    end else if (!i_byte_valid) begin
                        r_idle <= r_idle + TW'(1);
                    end else begin
                        r_idle  <= '0;
                        r_shift <= w_word[23:0];
                        r_bcnt  <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                            case (r_state)
                                S_LEN: begin
                                    r_len <= w_word[LEN_W-1:0];
                                    if (w_word[LEN_W-1:0] == '0) begin
                                        r_state <= S_ERROR;
                                        r_err   <= 1'b1;
                                        r_code  <= ERR_ZERO_LEN;
                                    end else begin
                                        r_state <= S_STREAM;
                                        r_sum   <= '0;
                                        r_wcnt  <= '0;
                                    end
                                end
                                S_STREAM: begin
                                    if (w_ovf) begin
                                        r_state <= S_ERROR;
                                        r_err   <= 1'b1;
                                        r_code  <= ERR_OVERFLOW;
                                    end else begin
                                        r_sum  <= r_sum + w_word;
                                        r_wcnt <= r_wcnt + LEN_W'(1);
                                        if (r_wcnt + LEN_W'(1) == r_len) begin
                                            r_state <= S_SUM;
                                        end
                                    end
                                end
                                default: begin
                                    r_trailer <= w_word;
                                    r_state   <= S_DRAIN;
                                end
                            endcase
                        end
                    end
                end

                S_DRAIN: begin
                    // Verdict only once every buffered word has gone out
                    if (w_empty) begin
                        if (r_trailer == r_sum) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_ERROR;
                            r_err   <= 1'b1;
                            r_code  <= ERR_CHECKSUM;
                        end
                    end
                end

                default: begin
                    // DONE and ERROR are sticky until abort or reset
                end
            endcase
        end
    end

    // Payload FIFO storage (data only, no reset needed)
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wp] <= w_word;
        end
    end

    // FIFO pointers and occupancy; abort or failure discards buffered words
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (w_flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push_ok) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            r_cnt <= r_cnt + CW'(w_push_ok) - CW'(w_pop);
        end
    end

    // ICAP strobe: one csib=0 cycle per popped word, data held between strobes
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_csib <= 1'b1;
            r_icap <= '0;
        end else begin
            r_csib <= !w_pop;
            if (w_pop) begin
                r_icap <= f_icap_format(r_mem[r_rp]);
            end
        end
    end

    assign o_icap_data        = r_icap;
    assign o_icap_csib        = r_csib;
    assign o_icap_rdwrb       = !w_writing;
    assign o_programming_done = r_done;
    assign o_load_error       = r_err;
    assign o_err_code         = r_code;
    assign o_loader_busy      = w_in_load;

endmodule

// File: tb/tb_icap_load_sequencer.sv
// Bench for icap_load_sequencer: directed loads from the reference vectors,
// then randomized loads (noise, gaps, busy patterns, bad trailers, aborts),
// all compared every cycle against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_icap_load_sequencer;

    localparam int          DEPTH = 16;
    localparam int          TO    = 200;
    localparam logic [31:0] MAGIC = 32'h5A5AC3C3;

`ifdef ICAP_BITSWAP_EN
    localparam logic [31:0] EXP_W0 = 32'h8844CC22;
    localparam logic [31:0] EXP_W1 = 32'hAA66EE11;
`else
    localparam logic [31:0] EXP_W0 = 32'h11223344;
    localparam logic [31:0] EXP_W1 = 32'h55667788;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        bv = 1'b0;
    logic        ab = 1'b0;
    logic        busy = 1'b0;

    logic [31:0] o_icap_data;
    logic        o_icap_csib;
    logic        o_icap_rdwrb;
    logic        o_programming_done;
    logic        o_load_error;
    logic [2:0]  o_err_code;
    logic        o_loader_busy;

    always #5 clk = ~clk;

    icap_load_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .LEN_W      (24),
        .MAGIC      (MAGIC),
        .TIMEOUT_CYC(TO)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_byte_in         (byte_in),
        .i_byte_valid      (bv),
        .i_abort           (ab),
        .i_icap_busy       (busy),
        .o_icap_data       (o_icap_data),
        .o_icap_csib       (o_icap_csib),
        .o_icap_rdwrb      (o_icap_rdwrb),
        .o_programming_done(o_programming_done),
        .o_load_error      (o_load_error),
        .o_err_code        (o_err_code),
        .o_loader_busy     (o_loader_busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;
    int busy_mode = 0;
    logic [31:0] got [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 hunt, 1 length, 2 payload, 3 trailer, 4 drain, 5 done, 6 error
    int          m_phase = 0;
    logic [31:0] m_sh = 0;
    logic [31:0] m_acc = 0;
    int          m_k = 0;
    int          m_n = 0;
    int          m_cnt = 0;
    int          m_idle = 0;
    logic [31:0] m_sum = 0;
    logic [31:0] m_T = 0;
    logic [31:0] m_q [$];
    bit          m_csib = 1'b1;
    logic [31:0] m_icap = 0;
    bit          m_done = 1'b0;
    bit          m_err = 1'b0;
    int          m_code = 0;
    bit          m_flash = 1'b0;

    function automatic logic [31:0] fmt(input logic [31:0] w);
        logic [31:0] r;
        r = w;
`ifdef ICAP_BITSWAP_EN
        for (int i = 0; i < 32; i++) r[(i / 8) * 8 + 7 - (i % 8)] = w[i];
`endif
        return r;
    endfunction

    task automatic m_fail(input int c);
        m_phase = 6;
        m_err   = 1'b1;
        m_code  = c;
        m_q.delete();
    endtask

    always @(posedge clk) begin : model
        logic [31:0] head;
        bit can_pop;
        bit did_pop;
        head = 0;
        can_pop = 1'b0;
        did_pop = 1'b0;
        if (!rst) begin
            m_phase = 0; m_sh = 0; m_q.delete();
            m_csib = 1'b1; m_icap = 0; m_done = 1'b0; m_err = 1'b0; m_code = 0; m_flash = 1'b0;
        end else begin
            if (m_flash) begin
                m_err = 1'b0; m_code = 0; m_flash = 1'b0;
            end
            if (ab) begin
                if (m_phase >= 1 && m_phase <= 4) begin
                    m_err = 1'b1; m_code = 5; m_flash = 1'b1;
                end else begin
                    m_err = 1'b0; m_code = 0;
                end
                m_done = 1'b0; m_phase = 0; m_sh = 0; m_q.delete();
            end else begin
                can_pop = (m_phase >= 2 && m_phase <= 4) && (m_q.size() > 0) && !busy;
                case (m_phase)
                    0: if (bv) begin
                        m_sh = {m_sh[23:0], byte_in};
                        if (m_sh == MAGIC) begin
                            m_phase = 1; m_k = 0; m_idle = 0;
                        end
                    end
                    1, 2, 3: begin
                        if (!bv) begin
                            m_idle++;
                            if (m_idle == TO) m_fail(4);
                        end else begin
                            m_idle = 0;
                            m_acc = {m_acc[23:0], byte_in};
                            m_k++;
                            if (m_k == 4) begin
                                m_k = 0;
                                if (m_phase == 1) begin
                                    m_n = int'(m_acc[23:0]);
                                    if (m_n == 0) m_fail(1);
                                    else begin
                                        m_phase = 2; m_sum = 0; m_cnt = 0;
                                    end
                                end else if (m_phase == 2) begin
                                    if (m_q.size() == DEPTH && !can_pop) m_fail(2);
                                    else begin
                                        if (can_pop) begin
                                            head = m_q.pop_front(); did_pop = 1'b1;
                                        end
                                        m_q.push_back(m_acc);
                                        m_sum = m_sum + m_acc;
                                        m_cnt++;
                                        if (m_cnt == m_n) m_phase = 3;
                                    end
                                end else begin
                                    m_T = m_acc; m_phase = 4;
                                end
                            end
                        end
                    end
                    4: if (m_q.size() == 0) begin
                        if (m_T == m_sum) begin
                            m_phase = 5; m_done = 1'b1;
                        end else m_fail(3);
                    end
                    default: ;
                endcase
                if (can_pop && !did_pop && m_phase != 6) begin
                    head = m_q.pop_front(); did_pop = 1'b1;
                end
            end
            if (did_pop) m_icap = fmt(head);
            m_csib = !did_pop;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("csib", o_icap_csib, m_csib);
            check("icap_data", o_icap_data, m_icap);
            check("rdwrb", o_icap_rdwrb, !(m_phase >= 2 && m_phase <= 4));
            check("done", o_programming_done, m_done);
            check("load_error", o_load_error, m_err);
            check("err_code", o_err_code, 32'(m_code));
            check("loader_busy", o_loader_busy, (m_phase >= 1 && m_phase <= 4));
            if (!o_icap_csib) got.push_back(o_icap_data);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
        if (busy_mode == 2) busy = 1'($urandom_range(0, 1));
        else busy = (busy_mode == 1);
    endtask

    task automatic send_byte(input logic [7:0] v, input int maxgap);
        byte_in = v;
        bv = 1'b1;
        tick();
        bv = 1'b0;
        byte_in = 8'($urandom);
        repeat ($urandom_range(0, maxgap)) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], maxgap);
    endtask

    task automatic do_abort();
        ab = 1'b1;
        tick();
        ab = 1'b0;
    endtask

    task automatic wait_end(input string name, input int maxc);
        int c;
        c = 0;
        while (!(o_programming_done || o_load_error) && c < maxc) begin
            tick();
            c++;
        end
        check({name, "_finished"}, (o_programming_done || o_load_error), 1);
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] sum;
        int n;
        int abort_at;
        bit bad;
        bit aborted;

        // Reset
        rst = 1'b0;
        repeat (3) tick();
        chk_en = 1'b1;
        tick();
        check("rst_csib", o_icap_csib, 1);
        check("rst_rdwrb", o_icap_rdwrb, 1);
        check("rst_icap", o_icap_data, 0);
        check("rst_flags", {o_programming_done, o_load_error, o_err_code, o_loader_busy}, 0);
        rst = 1'b1;
        tick();

        // Reference load, busy low
        got.delete();
        busy_mode = 0;
        send_word(MAGIC, 0);
        send_word(32'h00000002, 0);
        send_word(32'h11223344, 0);
        send_word(32'h55667788, 0);
        send_word(32'h6688AACC, 0);
        wait_end("ref_load", 50);
        tick();
        check("ref_done", o_programming_done, 1);
        check("ref_code", o_err_code, 0);
        check("ref_npulses", got.size(), 2);
        if (got.size() >= 2) begin
            check("ref_word0", got[0], EXP_W0);
            check("ref_word1", got[1], EXP_W1);
        end

        // Same with corrupted trailer
        do_abort();
        check("abort_from_done_clears", o_programming_done, 0);
        got.delete();
        send_word(MAGIC, 0);
        send_word(32'h00000002, 0);
        send_word(32'h11223344, 0);
        send_word(32'h55667788, 0);
        send_word(32'h6688AACD, 0);
        wait_end("bad_sum", 50);
        tick();
        check("bad_sum_err", o_load_error, 1);
        check("bad_sum_code", o_err_code, 3);
        check("bad_sum_npulses", got.size(), 2);

        // Zero length
        do_abort();
        got.delete();
        send_word(MAGIC, 0);
        send_word(32'h00000000, 0);
        repeat (3) tick();
        check("zero_len_code", o_err_code, 1);
        check("zero_len_npulses", got.size(), 0);

        // Overflow with busy held
        do_abort();
        got.delete();
        busy_mode = 1;
        tick();
        send_word(MAGIC, 0);
        send_word(32'h00000014, 0);
        for (int i = 0; i < 17; i++) send_word(32'($urandom), 0);
        check("ovf_code", o_err_code, 2);
        check("ovf_npulses", got.size(), 0);
        busy_mode = 0;

        // Timeout
        do_abort();
        send_word(MAGIC, 0);
        send_word(32'h00000002, 0);
        send_byte(8'h11, 0);
        repeat (TO + 5) tick();
        check("timeout_code", o_err_code, 4);

        // Abort mid-stream
        do_abort();
        busy_mode = 2;
        send_word(MAGIC, 0);
        send_word(32'h00000004, 0);
        send_word(32'hDEADBEEF, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        do_abort();
        busy_mode = 0;
        check("abort_busy", o_loader_busy, 0);
        check("abort_pulse_code", o_err_code, 5);
        got.delete();
        repeat (10) tick();
        check("abort_no_pulses", got.size(), 0);
        check("abort_pulse_cleared", o_load_error, 0);

        // Fresh load after abort
        send_word(MAGIC, 1);
        send_word(32'h00000001, 1);
        send_word(32'hCAFEF00D, 1);
        send_word(32'hCAFEF00D, 1);
        wait_end("fresh", 50);
        check("fresh_done", o_programming_done, 1);

        // Randomized loads
        for (int t = 0; t < 25; t++) begin
            do_abort();
            n = $urandom_range(1, 24);
            busy_mode = $urandom_range(0, 2);
            if (busy_mode == 1 && n > DEPTH) busy_mode = 2;
            bad = ($urandom_range(0, 3) == 0);
            abort_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
            aborted = 1'b0;
            repeat ($urandom_range(0, 5)) send_byte(8'($urandom), 1);
            send_word(MAGIC, 2);
            send_word({8'($urandom), 24'(n)}, 2);
            sum = 0;
            for (int i = 0; i < n; i++) begin
                if (i == abort_at) begin
                    do_abort();
                    aborted = 1'b1;
                    break;
                end
                w = $urandom;
                sum = sum + w;
                send_word(w, 3);
            end
            if (!aborted) begin
                if (bad) sum = sum ^ (32'h1 << $urandom_range(0, 31));
                send_word(sum, 2);
                busy_mode = 0;
                wait_end("rand_load", 200);
                check("rand_done", o_programming_done, !bad);
                check("rand_code", o_err_code, bad ? 3 : 0);
            end
            busy_mode = 0;
        end

        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
